// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// codes, the multiply/divide sequencer state encoding and register-match
// helpers used by the hazard and forwarding terms.
package hazard_ctrl_pkg;

  // Execute-stage operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Multiply/divide sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } md_state_e;

  // A destination matches a source only for a real register; r0 is
  // hard-wired to zero and never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  // Operand select for one execute source. The memory stage holds the
  // younger result, so it takes priority over writeback.
  function automatic logic [1:0] fwd_select(
    input logic       wr_m,
    input logic [4:0] dst_m,
    input logic       wr_w,
    input logic [4:0] dst_w,
    input logic [4:0] src
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_m && reg_hit(dst_m, src)) begin
      sel = FWD_MEM;
    end else if (wr_w && reg_hit(dst_w, src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// Multiply/divide sequencer: holds execute for MD_LATENCY cycles (the
// start cycle plus MD_LATENCY-1 BUSY cycles), then spends one DONE cycle
// in which the result is valid and the instruction advances.
module md_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic MdStartE,
  output logic MdBusy,
  output logic MdDone
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update; DONE ignores MdStartE so the finishing
  // instruction cannot start itself again.
  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (MdStartE) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs; forced low while reset is asserted so an aborted
  // operation releases the pipeline in the same cycle.
  always_comb begin
    MdBusy = 1'b0;
    MdDone = 1'b0;
    if (rst) begin
      MdBusy = ((state_q == IDLE) && MdStartE) || (state_q == BUSY);
      MdDone = (state_q == DONE);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: execute-stage forwarding, load-use and
// branch-operand hazard detection, multiply/divide hold sequencing and a
// saturating count of decode-stall cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic        BranchD,
  input  logic        PCSrcD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemToRegE,
  input  logic        MemToRegM,
  input  logic        MdStartE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MdBusy,
  output logic        MdDone,
  output logic [31:0] StallCycles
);

  logic lwstall;
  logic brstall;
  logic mdhold;
  logic md_busy;
  logic md_done;

  md_seq #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_md_seq (
    .clk      (clk),
    .rst      (rst),
    .MdStartE (MdStartE),
    .MdBusy   (md_busy),
    .MdDone   (md_done)
  );

  // The sequencer's busy output is exactly the execute hold condition.
  assign mdhold = md_busy;
  assign MdBusy = md_busy;
  assign MdDone = md_done;

  // Hazard detection: a load in execute feeding decode, or a decode-stage
  // branch whose operand is still being produced in execute or loaded in memory.
  always_comb begin
    lwstall = MemToRegE && RegWriteE &&
              (reg_hit(WriteRegE, RsD) || reg_hit(WriteRegE, RtD));
    brstall = BranchD &&
              ((RegWriteE && (reg_hit(WriteRegE, RsD) || reg_hit(WriteRegE, RtD))) ||
               (MemToRegM && (reg_hit(WriteRegM, RsD) || reg_hit(WriteRegM, RtD))));
  end

  // Pipeline control outputs, all forced low during reset. A held
  // multiply/divide is never flushed, and a taken branch is not acted on
  // while decode is stalled; it resolves again once the stall clears.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (rst) begin
      StallD    = lwstall || brstall || mdhold;
      StallF    = StallD;
      StallE    = mdhold;
      FlushE    = (lwstall || brstall) && !mdhold;
      FlushD    = PCSrcD && !StallD;
      ForwardAE = fwd_select(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RsE);
      ForwardBE = fwd_select(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RtE);
    end
  end

  // Saturating count of cycles in which decode was stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCycles <= '0;
    end else if (StallD && (StallCycles != 32'hFFFF_FFFF)) begin
      StallCycles <= StallCycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model.
module tb_hazard_ctrl;

  localparam int MD_LATENCY = 4;
  localparam int CNT_W      = 3;

  logic        clk;
  logic        rst;
  logic [4:0]  RsD, RtD, RsE, RtE;
  logic        BranchD, PCSrcD;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW;
  logic        MemToRegE, MemToRegM, MdStartE;
  logic        StallF, StallD, StallE, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        MdBusy, MdDone;
  logic [31:0] StallCycles;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RsD         (RsD),
    .RtD         (RtD),
    .BranchD     (BranchD),
    .PCSrcD      (PCSrcD),
    .RsE         (RsE),
    .RtE         (RtE),
    .WriteRegE   (WriteRegE),
    .WriteRegM   (WriteRegM),
    .WriteRegW   (WriteRegW),
    .RegWriteE   (RegWriteE),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .MemToRegE   (MemToRegE),
    .MemToRegM   (MemToRegM),
    .MdStartE    (MdStartE),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .MdBusy      (MdBusy),
    .MdDone      (MdDone),
    .StallCycles (StallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    RsD = 5'd0; RtD = 5'd0; BranchD = 1'b0; PCSrcD = 1'b0;
    RsE = 5'd0; RtE = 5'd0;
    WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemToRegE = 1'b0; MemToRegM = 1'b0; MdStartE = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  // md_cycle: 0 = no multiply/divide in flight; otherwise the 1-based
  // position within the operation (1..MD_LATENCY hold cycles, then one done cycle).
  int          md_cycle = 0;
  logic [31:0] exp_cnt  = 32'd0;

  function automatic logic same_reg(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (RegWriteW && same_reg(WriteRegW, src)) sel = 2'b01;
    if (RegWriteM && same_reg(WriteRegM, src)) sel = 2'b10;  // younger result overrides
    return sel;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        md_cycle = 0;
        exp_cnt  = 32'd0;
        check("rst_stalld", {31'd0, StallD}, 32'd0);
        check("rst_stalle", {31'd0, StallE}, 32'd0);
        check("rst_flush",  {30'd0, FlushD, FlushE}, 32'd0);
        check("rst_fwd",    {28'd0, ForwardAE, ForwardBE}, 32'd0);
        check("rst_md",     {30'd0, MdBusy, MdDone}, 32'd0);
        check("rst_cnt",    StallCycles, 32'd0);
      end else begin
        logic starting, hold, done, lw, br, sd;
        starting = (md_cycle == 0) && MdStartE;
        hold     = starting || (md_cycle >= 2 && md_cycle <= MD_LATENCY);
        done     = (md_cycle == MD_LATENCY + 1);
        lw = MemToRegE && RegWriteE && (same_reg(WriteRegE, RsD) || same_reg(WriteRegE, RtD));
        br = BranchD && ((RegWriteE && (same_reg(WriteRegE, RsD) || same_reg(WriteRegE, RtD))) ||
                         (MemToRegM && (same_reg(WriteRegM, RsD) || same_reg(WriteRegM, RtD))));
        sd = lw || br || hold;
        check("m_stallf", {31'd0, StallF}, {31'd0, sd});
        check("m_stalld", {31'd0, StallD}, {31'd0, sd});
        check("m_stalle", {31'd0, StallE}, {31'd0, hold});
        check("m_flushe", {31'd0, FlushE}, {31'd0, (lw || br) && !hold});
        check("m_flushd", {31'd0, FlushD}, {31'd0, PCSrcD && !sd});
        check("m_fwda",   {30'd0, ForwardAE}, {30'd0, model_fwd(RsE)});
        check("m_fwdb",   {30'd0, ForwardBE}, {30'd0, model_fwd(RtE)});
        check("m_busy",   {31'd0, MdBusy}, {31'd0, hold});
        check("m_done",   {31'd0, MdDone}, {31'd0, done});
        check("m_cnt",    StallCycles, exp_cnt);
        // advance to the values that follow the next rising edge
        if (sd && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
        if (md_cycle == 0)                   md_cycle = MdStartE ? 2 : 0;
        else if (md_cycle == MD_LATENCY + 1) md_cycle = 0;
        else                                 md_cycle = md_cycle + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    set_idle();
    // Forwarding match present during reset must still read as zero.
    RsE = 5'd5; WriteRegM = 5'd5; RegWriteM = 1'b1;
    MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5; RsD = 5'd5;
    #2;
    check("reset_fwda", {30'd0, ForwardAE}, 32'd0);
    check("reset_stalld", {31'd0, StallD}, 32'd0);
    step(); step();
    check("reset_cnt", StallCycles, 32'd0);
    rst = 1'b1;
    set_idle();

    // Forward priority
    step();
    RsE = 5'd5; WriteRegM = 5'd5; WriteRegW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1 check("fwd_mem_wins", {30'd0, ForwardAE}, 32'h2);
    RegWriteM = 1'b0;
    #1 check("fwd_wb", {30'd0, ForwardAE}, 32'h1);
    RsE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0; RegWriteM = 1'b1;
    #1 check("fwd_r0", {30'd0, ForwardAE}, 32'h0);
    RtE = 5'd7; WriteRegW = 5'd7;
    #1 check("fwd_b_wb", {30'd0, ForwardBE}, 32'h1);

    // Load-use
    step(); set_idle();
    MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RtD = 5'd8;
    #1 check("lw_stall", {29'd0, StallF, StallD, FlushE}, 32'h7);
    check("lw_no_stalle", {31'd0, StallE}, 32'h0);
    step();
    WriteRegE = 5'd0; RtD = 5'd0;
    #1 check("lw_r0", {29'd0, StallF, StallD, FlushE}, 32'h0);

    // Branch operand
    step(); set_idle();
    BranchD = 1'b1; RsD = 5'd3; MemToRegM = 1'b1; WriteRegM = 5'd3; PCSrcD = 1'b1;
    #1 check("br_stall", {29'd0, StallD, FlushE, FlushD}, 32'h6);
    step(); set_idle();
    PCSrcD = 1'b1;
    #1 check("br_taken", {30'd0, StallD, FlushD}, 32'h1);

    // Multiply/divide with a load-use overlap, from a fresh counter
    step(); set_idle(); rst = 1'b0;
    step(); rst = 1'b1;
    step();
    MdStartE = 1'b1; MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
    #1 check("md_cnt_start", StallCycles, 32'd0);
    for (int c = 1; c <= MD_LATENCY; c++) begin
      if (c > 1) step();
      #1 check("md_hold", {27'd0, StallE, StallD, FlushE, MdBusy, MdDone}, 32'b11010);
    end
    step();
    #1 check("md_done", {27'd0, StallE, StallD, FlushE, MdBusy, MdDone}, 32'b01101);
    step(); set_idle();
    #1 check("md_cnt_5", StallCycles, 32'd5);
    check("md_idle", {30'd0, MdBusy, MdDone}, 32'd0);

    // Reset mid-BUSY
    step(); MdStartE = 1'b1;
    MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9;
    RsE = 5'd4; WriteRegM = 5'd4; RegWriteM = 1'b1;
    step(); step();
    #1 check("abort_pre", {31'd0, StallE}, 32'd1);
    rst = 1'b0;
    #1 check("abort_outs", {23'd0, StallF, StallD, StallE, FlushD, FlushE, ForwardAE, MdBusy, MdDone}, 32'd0);
    step(); set_idle();
    step(); rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1 check("abort_no_done", {30'd0, MdBusy, MdDone}, 32'd0);
      step();
    end

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 149) != 0);
      RsD       = 5'($urandom_range(0, 3));
      RtD       = 5'($urandom_range(0, 3));
      RsE       = 5'($urandom_range(0, 3));
      RtE       = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      BranchD   = 1'($urandom_range(0, 1));
      PCSrcD    = 1'($urandom_range(0, 1));
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemToRegE = 1'($urandom_range(0, 1));
      MemToRegM = 1'($urandom_range(0, 1));
      MdStartE  = ($urandom_range(0, 3) == 0);
      step();
    end
    set_idle();
    rst = 1'b1;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core; it sequences the decode-to-execute pipeline register and the stages around it. It computes forwarding selects for the execute stage and detects load-use and branch-operand hazards. It also runs a counter FSM that holds the pipeline while a multi-cycle multiply/divide occupies execute. Its outputs drive the PC enable, the fetch-to-decode enable/clear and the decode-to-execute enable/clear. It sits beside the pipeline registers in the core.

## Interface
- MD_LATENCY, 32, execute-stage cycles a multiply/divide occupies (≥2)
- CNT_W, 6, width of the latency down-counter (2^CNT_W > MD_LATENCY)
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- RsD, RtD  in  5  source registers in decode
- BranchD  in  1  decode holds a branch that compares operands in decode
- PCSrcD  in  1  branch/jump taken, resolved in decode
- RsE, RtE  in  5  source registers in execute
- WriteRegE, WriteRegM, WriteRegW  in  5  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  stage writes the register file
- MemToRegE, MemToRegM  in  1  stage holds a load
- MdStartE  in  1  execute holds a multiply/divide
- StallF, StallD, StallE  out  1  hold PC / fetch-to-decode / decode-to-execute registers
- FlushD, FlushE  out  1  synchronous clear of fetch-to-decode / decode-to-execute registers
- ForwardAE, ForwardBE  out  2  execute operand select: 00 register file, 01 writeback, 10 memory
- MdBusy  out  1  multiply/divide in progress
- MdDone  out  1  one-cycle pulse, result valid this cycle
- StallCycles  out  32  saturating count of cycles with StallD=1

## Operation
- Register 0 never matches any hazard or forward term.
- Forward A: 10 if RegWriteM and WriteRegM==RsE; else 01 if RegWriteW and WriteRegW==RsE; else 00. Memory stage wins over writeback. B is the same with RtE.
- lwstall = MemToRegE & RegWriteE & (WriteRegE==RsD | WriteRegE==RtD).
- brstall = BranchD & ((RegWriteE & WriteRegE∈{RsD,RtD}) | (MemToRegM & WriteRegM∈{RsD,RtD})).
- FSM states:
  - IDLE → BUSY when MdStartE=1; counter loads MD_LATENCY-2.
  - BUSY: counter decrements each cycle; at counter==0 → DONE.
  - DONE → IDLE unconditionally. MdStartE is ignored in DONE, so the same instruction cannot retrigger.
- mdhold = (state==IDLE & MdStartE) | state==BUSY.
- MdBusy = mdhold. MdDone = (state==DONE).
- StallF = StallD = lwstall | brstall | mdhold. StallE = mdhold.
- FlushE = (lwstall | brstall) & ~mdhold. The multiply/divide instruction is never killed.
- FlushD = PCSrcD & ~StallD.
- StallCycles increments when StallD=1 and saturates at 32'hFFFFFFFF.

## Timing
- Forward, stall and flush outputs are combinational from inputs and state, with zero latency.
- A multiply/divide holds execute for exactly MD_LATENCY cycles: the start cycle plus MD_LATENCY-1 BUSY cycles. DONE follows, and the instruction advances at the end of DONE.
- Reset values: state IDLE, counter 0, StallCycles 0. While rst=0, every output is forced to 0.
- Reset asserted mid-BUSY aborts the operation immediately: MdDone is not pulsed and stalls drop the same cycle.
- Simultaneous load-use and multiply/divide start: stall and hold everything, no FlushE. lwstall re-evaluates after DONE.
- PCSrcD together with any stall: FlushD=0, and the branch is re-resolved after the stall.

## Structure
- Shared core package holds the forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 and the FSM state encoding (IDLE, BUSY, DONE).
- Sub-module md_seq holds the FSM, the counter, and the MdBusy/MdDone outputs. The hazard/forward logic and StallCycles live in the top level.

## Test plan
- Forward priority: RsE=5, WriteRegM=5, WriteRegW=5, both RegWrite=1 → ForwardAE=10. Set RegWriteM=0 → 01. Set RsE=0 with matches on register 0 → 00.
- Load-use: MemToRegE=1, RegWriteE=1, WriteRegE=8, RtD=8 → StallF=StallD=FlushE=1 for one cycle. Repeat with WriteRegE=0 → no stall.
- Branch operand: BranchD=1, RsD=3, MemToRegM=1, WriteRegM=3 → StallD=1, FlushE=1, FlushD=0 even with PCSrcD=1. Next cycle, inputs clear and PCSrcD=1 → FlushD=1.
- Multiply/divide, MD_LATENCY=4: MdStartE held high → StallE=1 for 4 cycles, MdDone pulses once on cycle 5, then IDLE. No retrigger while MdStartE stays 1 in DONE.
- Overlap: a load-use condition present during BUSY → FlushE=0 throughout; StallCycles advances by 5 over the sequence.
- Reset mid-BUSY: rst=0 at counter==1 → all outputs 0 immediately and state IDLE after release. No MdDone pulse.
